// File: rtl/usb_eop_seq_detect.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// usb_eop_seq_detect
//
// Sequential end-of-packet detector for the USB receive path. It samples the
// synchronised D+/D- pair once per bit time (qualified by shift_enable) and
// counts consecutive SE0 bits.
//
// A legal EOP is SE0 for SE0_MIN..SE0_MAX bit times followed by exactly one
// J bit. Any other way of leaving an SE0 run is reported as a malformed EOP.
// RESET_BITS consecutive SE0 bits are a bus reset; the detector then holds in
// reset until the first non-SE0 bit.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset (outranks every other event)
//   shift_enable one-cycle bit-sample strobe; the line is sampled only then
//   d_plus       synchronised D+
//   d_minus      synchronised D-
//   se0          registered level: last sampled bit was SE0
//   eop          one-cycle pulse: legal EOP completed
//   eop_err      one-cycle pulse: malformed SE0/EOP
//   bus_reset    one-cycle pulse on bus reset detection
//   in_reset     level, high while the bus is held in reset
// -----------------------------------------------------------------------------
module usb_eop_seq_detect #(
  parameter int SE0_MIN    = 2,
  parameter int SE0_MAX    = 3,
  parameter int RESET_BITS = 16,
  parameter int CNT_W      = $clog2(RESET_BITS + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic shift_enable,
  input  logic d_plus,
  input  logic d_minus,
  output logic se0,
  output logic eop,
  output logic eop_err,
  output logic bus_reset,
  output logic in_reset
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SE0_CNT    = 2'd1,
    RESET_HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(SE0_MIN);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(SE0_MAX);
  localparam logic [CNT_W-1:0] RESET_C = CNT_W'(RESET_BITS);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic             line_se0;
  logic             line_j;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_legal;

  // Line decode; SE1 (1,1) falls out as neither SE0 nor J.
  assign line_se0  = ~d_plus & ~d_minus;
  assign line_j    =  d_plus & ~d_minus;

  // In SE0_CNT the count never exceeds RESET_BITS-1, so the increment cannot
  // overflow CNT_W bits.
  assign cnt_inc   = cnt + 1'b1;
  assign cnt_legal = (cnt >= MIN_C) && (cnt <= MAX_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      se0       <= 1'b0;
      eop       <= 1'b0;
      eop_err   <= 1'b0;
      bus_reset <= 1'b0;
      in_reset  <= 1'b0;
    end else begin
      // Pulses default low so each lasts exactly one cycle.
      eop       <= 1'b0;
      eop_err   <= 1'b0;
      bus_reset <= 1'b0;

      if (shift_enable) begin
        se0 <= line_se0;

        case (state)
          IDLE: begin
            if (line_se0) begin
              state <= SE0_CNT;
              cnt   <= CNT_W'(1);
            end
          end

          SE0_CNT: begin
            if (line_se0) begin
              if (cnt_inc == RESET_C) begin
                // Counter parks at RESET_BITS; it never wraps.
                state     <= RESET_HOLD;
                cnt       <= RESET_C;
                bus_reset <= 1'b1;
                in_reset  <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              // First non-SE0 bit decides the fate of the SE0 run.
              if (cnt_legal && line_j) begin
                eop <= 1'b1;
              end else begin
                eop_err <= 1'b1;
              end
              state <= IDLE;
              cnt   <= '0;
            end
          end

          RESET_HOLD: begin
            // Leaving bus reset is silent: no eop, no eop_err.
            if (!line_se0) begin
              state    <= IDLE;
              cnt      <= '0;
              in_reset <= 1'b0;
            end
          end

          default: begin
            state    <= IDLE;
            cnt      <= '0;
            in_reset <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_eop_seq_detect.sv
`timescale 1ns/1ps
// Scoreboard bench for usb_eop_seq_detect. Two instances share the stimulus:
// dut_a uses default parameters, dut_b uses SE0_MIN=1, SE0_MAX=1, RESET_BITS=4.
// Each driven cycle pushes a hand-computed expected output vector
// {se0, eop, eop_err, bus_reset, in_reset} for the selected instance; the
// monitor pops and compares once the cycle it applies to has been clocked.
module tb_usb_eop_seq_detect;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic shift_enable = 1'b0;
  logic d_plus = 1'b1;
  logic d_minus = 1'b0;

  logic se0_a, eop_a, eop_err_a, bus_reset_a, in_reset_a;
  logic se0_b, eop_b, eop_err_b, bus_reset_b, in_reset_b;

  localparam logic [1:0] L_SE0 = 2'b00;
  localparam logic [1:0] L_J   = 2'b10;
  localparam logic [1:0] L_K   = 2'b01;
  localparam logic [1:0] L_SE1 = 2'b11;

  localparam logic [4:0] O_NONE = 5'b00000;
  localparam logic [4:0] O_SE0  = 5'b10000;
  localparam logic [4:0] O_EOP  = 5'b01000;
  localparam logic [4:0] O_ERR  = 5'b00100;
  localparam logic [4:0] O_BRST = 5'b10011;
  localparam logic [4:0] O_HOLD = 5'b10001;

  usb_eop_seq_detect dut_a (
    .clk(clk), .rst(rst), .shift_enable(shift_enable),
    .d_plus(d_plus), .d_minus(d_minus),
    .se0(se0_a), .eop(eop_a), .eop_err(eop_err_a),
    .bus_reset(bus_reset_a), .in_reset(in_reset_a)
  );

  usb_eop_seq_detect #(.SE0_MIN(1), .SE0_MAX(1), .RESET_BITS(4)) dut_b (
    .clk(clk), .rst(rst), .shift_enable(shift_enable),
    .d_plus(d_plus), .d_minus(d_minus),
    .se0(se0_b), .eop(eop_b), .eop_err(eop_err_b),
    .bus_reset(bus_reset_b), .in_reset(in_reset_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    bit         sel;
    logic [4:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  logic [4:0] vec_a, vec_b;
  assign vec_a = {se0_a, eop_a, eop_err_a, bus_reset_a, in_reset_a};
  assign vec_b = {se0_b, eop_b, eop_err_b, bus_reset_b, in_reset_b};

  // Monitor: compares every expectation whose cycle has been clocked.
  initial begin
    exp_t e;
    logic [4:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        act = e.sel ? vec_b : vec_a;
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s (dut_%s cyc %0d): got {se0,eop,err,brst,inrst}=%b expected %b",
                   e.name, e.sel ? "b" : "a", e.due, act, e.exp);
        end
      end
    end
  end

  task automatic step(input bit sel, input logic r, input logic se,
                      input logic [1:0] line, input logic [4:0] exp,
                      input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    shift_enable = se;
    d_plus       = line[1];
    d_minus      = line[0];
    e.due  = cyc + 1;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
  endtask

  // n consecutive SE0 strobes, each expected to leave se0=1 and no pulse.
  task automatic se0_run(input bit sel, input int n, input string name);
    for (int i = 0; i < n; i++) step(sel, 1'b0, 1'b1, L_SE0, O_SE0, name);
  endtask

  initial begin
    // Reset state
    step(0, 1, 0, L_J, O_NONE, "reset_state");
    step(0, 1, 0, L_J, O_NONE, "reset_state");

    // Reset mid-count wins over a J strobe; the following J is not an EOP
    se0_run(0, 2, "pre_rst_se0");
    step(0, 1, 1, L_J, O_NONE, "rst_mid_cnt");
    step(0, 0, 1, L_J, O_NONE, "no_eop_after_rst");
    step(0, 0, 0, L_J, O_NONE, "idle_after_rst");

    // Legal EOP, then a back-to-back legal EOP at SE0_MAX
    se0_run(0, 2, "eop_se0");
    step(0, 0, 1, L_J, O_EOP, "eop_pulse");
    se0_run(0, 3, "eop_max_se0");
    step(0, 0, 1, L_J, O_EOP, "eop_at_max");
    step(0, 0, 0, L_J, O_NONE, "eop_one_cycle");

    // Strobe gating: idle cycles hold se0 and are otherwise ignored
    se0_run(0, 1, "gate_se0_1");
    for (int i = 0; i < 5; i++) step(0, 0, 0, L_J, O_SE0, "gate_idle");
    se0_run(0, 1, "gate_se0_2");
    step(0, 0, 1, L_J, O_EOP, "gate_eop");
    step(0, 0, 0, L_J, O_NONE, "gate_after");

    // Short SE0
    se0_run(0, 1, "short_se0");
    step(0, 0, 1, L_J, O_ERR, "short_err");
    step(0, 0, 0, L_J, O_NONE, "short_after");
    // Long SE0
    se0_run(0, 4, "long_se0");
    step(0, 0, 1, L_J, O_ERR, "long_err");
    // K after legal count
    se0_run(0, 2, "k_se0");
    step(0, 0, 1, L_K, O_ERR, "k_err");
    // SE1 after legal count
    se0_run(0, 2, "se1_se0");
    step(0, 0, 1, L_SE1, O_ERR, "se1_err");
    step(0, 0, 0, L_J, O_NONE, "se1_after");

    // Bus reset at 16 SE0 bits, hold, then silent exit
    se0_run(0, 15, "brst_se0");
    step(0, 0, 1, L_SE0, O_BRST, "bus_reset_pulse");
    for (int i = 0; i < 4; i++) step(0, 0, 1, L_SE0, O_HOLD, "in_reset_hold");
    step(0, 0, 0, L_J, O_HOLD, "hold_idle");
    step(0, 0, 1, L_J, O_NONE, "reset_exit");
    step(0, 0, 0, L_J, O_NONE, "reset_exit_after");

    // rst during RESET_HOLD, then a fresh count starts at 1
    se0_run(0, 15, "brst2_se0");
    step(0, 0, 1, L_SE0, O_BRST, "bus_reset_pulse2");
    step(0, 1, 1, L_SE0, O_NONE, "rst_in_hold");
    se0_run(0, 1, "fresh_se0");
    step(0, 0, 1, L_J, O_ERR, "fresh_cnt_err");

    // Parameter sweep instance: SE0_MIN=1, SE0_MAX=1, RESET_BITS=4
    step(1, 1, 0, L_J, O_NONE, "b_reset");
    se0_run(1, 1, "b_se0");
    step(1, 0, 1, L_J, O_EOP, "b_eop");
    se0_run(1, 2, "b_long_se0");
    step(1, 0, 1, L_J, O_ERR, "b_long_err");
    se0_run(1, 3, "b_brst_se0");
    step(1, 0, 1, L_SE0, O_BRST, "b_bus_reset");
    step(1, 0, 1, L_SE0, O_HOLD, "b_hold");
    step(1, 0, 1, L_J, O_NONE, "b_exit");
    step(1, 0, 0, L_J, O_NONE, "b_after");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/usb_eop_seq_detect.md
Name: usb_eop_seq_detect

Overview:
- Parametrised, sequential successor to the combinational SE0/EOP decoder on the USB receive path.
- Samples d_plus/d_minus once per bit time, qualified by the bit-sample strobe, and counts consecutive SE0 bits.
- Validates a full USB end-of-packet: SE0 for SE0_MIN..SE0_MAX bit times, then one J bit.
- Also flags malformed EOPs and detects bus reset (long SE0). Sits between the line synchroniser and the receive controller FSM.

Parameters:
- SE0_MIN, 2, minimum consecutive SE0 bits for a legal EOP (>=1).
- SE0_MAX, 3, maximum consecutive SE0 bits still treated as EOP (>=SE0_MIN).
- RESET_BITS, 16, consecutive SE0 bits that signal bus reset (>SE0_MAX).
- CNT_W, $clog2(RESET_BITS+1), SE0 counter width (derived, do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- shift_enable  in  1  one-cycle bit-sample strobe; line sampled only when high.
- d_plus  in  1  synchronised D+ line.
- d_minus  in  1  synchronised D-.
- se0  out  1  registered level: last sampled bit was SE0.
- eop  out  1  one-cycle pulse: legal EOP completed.
- eop_err  out  1  one-cycle pulse: malformed SE0/EOP.
- bus_reset  out  1  one-cycle pulse on reset detection.
- in_reset  out  1  level, high while bus held in reset.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a clk edge): state=IDLE, cnt=0, all outputs 0. Takes priority over every other event, including mid-SE0 and RESET_HOLD.
- Line decode at strobe:
  - SE0 = d_plus=0 and d_minus=0.
  - J = d_plus=1, d_minus=0.
  - K = 0,1.
  - SE1 = 1,1, treated as non-J.
- No action on cycles with shift_enable=0. State, cnt and se0 hold; pulses are 0.
- se0 updates at every strobe to the sampled SE0 value, with 1-cycle latency.
- FSM states: IDLE, SE0_CNT, RESET_HOLD. All pulses are registered and high for exactly the cycle after the deciding strobe.
- IDLE:
  - strobe & SE0 -> SE0_CNT, cnt=1.
  - Otherwise stay.
- SE0_CNT, strobe & SE0:
  - If cnt+1 == RESET_BITS -> RESET_HOLD, bus_reset pulse.
  - Else cnt=cnt+1, stay.
- SE0_CNT, strobe & not SE0 (the deciding bit):
  - SE0_MIN<=cnt<=SE0_MAX and J -> eop pulse.
  - Any other combination (cnt<SE0_MIN, cnt>SE0_MAX, or K/SE1) -> eop_err pulse.
  - Next state IDLE, cnt=0 in all cases.
- RESET_HOLD: in_reset=1 (registered, rises together with the bus_reset pulse).
  - strobe & not SE0 -> IDLE, in_reset=0, no eop and no eop_err.
  - strobe & SE0 -> stay.
- Counter saturates at RESET_BITS and never wraps.
- eop, eop_err and bus_reset are mutually exclusive in any cycle.
- Back-to-back strobes (shift_enable high on consecutive cycles) each count as one bit.
- A strobe arriving the cycle after a pulse is evaluated normally.

Test Plan:
- Reset: rst=1 mid-SE0_CNT (cnt=2), then rst=0 and strobe with J -> no eop, all outputs 0, se0=0 after the next strobe.
- Legal EOP, defaults: strobes SE0,SE0,J -> eop=1 for exactly one cycle after the 3rd strobe; eop_err=0; se0 goes 1,1,0.
- Strobe gating: SE0 strobe, 5 idle cycles with lines at J, SE0 strobe, J strobe -> single eop pulse; idle cycles ignored.
- Short and long SE0:
  - SE0 then J -> eop_err pulse.
  - SE0 x4 then J -> eop_err (cnt=4 > SE0_MAX=3).
  - SE0 x2 then K -> eop_err.
- Bus reset: 16 consecutive SE0 strobes -> bus_reset pulse after the 16th; in_reset=1.
  - 4 further SE0 strobes -> in_reset stays 1, no pulses.
  - J strobe -> in_reset=0, no eop.
- Parameter sweep: SE0_MIN=1, SE0_MAX=1, RESET_BITS=4 -> SE0 then J gives eop; SE0 x4 gives bus_reset.
